// File: rtl/intensity_calc_pipe.sv
// Purpose: RGB -> intensity (weighted / max / min / fixed 1-2-1) with per-frame min/max/sum stats.
// Latency: 3 cycles from input acceptance to oVALID, one beat per cycle.
// Backpressure: global stall, oREADY = ~oVALID | iREADY; every stage holds while stalled.
module intensity_calc_pipe #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int SUM_W  = 30
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] iR,
  input  logic [DATA_W-1:0] iG,
  input  logic [DATA_W-1:0] iB,
  input  logic              iVALID,
  input  logic              iSOF,
  input  logic              iEOF,
  output logic              oREADY,
  output logic [DATA_W-1:0] oIntensity,
  output logic              oVALID,
  output logic              oSOF,
  output logic              oEOF,
  input  logic              iREADY,
  input  logic [1:0]        iMODE,
  input  logic              iWLOAD,
  input  logic [COEF_W-1:0] iWR,
  input  logic [COEF_W-1:0] iWG,
  input  logic [COEF_W-1:0] iWB,
  output logic [DATA_W-1:0] oSTAT_MIN,
  output logic [DATA_W-1:0] oSTAT_MAX,
  output logic [SUM_W-1:0]  oSTAT_SUM,
  output logic              oSTAT_VALID,
  output logic              oFRAME_ERR
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam int SUMX_W = SUM_W + 1;
  localparam logic [COEF_W-1:0] W_QTR  = COEF_W'(1) << (COEF_W - 2);
  localparam logic [COEF_W-1:0] W_HALF = COEF_W'(1) << (COEF_W - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic adv, sof_acc, take;

  // weight / mode registers
  logic [COEF_W-1:0] shd_wr_q, shd_wg_q, shd_wb_q, shd_wr_d, shd_wg_d, shd_wb_d;
  logic [COEF_W-1:0] act_wr_q, act_wg_q, act_wb_q, act_wr_d, act_wg_d, act_wb_d;
  logic [1:0]        act_mode_q, act_mode_d;

  // pipeline registers
  logic              s1_vld_q, s1_sof_q, s1_eof_q, s1_vld_d, s1_sof_d, s1_eof_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic [PROD_W-1:0] s1_pr_q, s1_pg_q, s1_pb_q, s1_pr_d, s1_pg_d, s1_pb_d;
  logic [DATA_W-1:0] s1_max_q, s1_min_q, s1_max_d, s1_min_d;
  logic              s2_vld_q, s2_sof_q, s2_eof_q, s2_vld_d, s2_sof_d, s2_eof_d;
  logic [1:0]        s2_mode_q, s2_mode_d;
  logic [ACC_W-1:0]  s2_sum_q, s2_sum_d;
  logic [DATA_W-1:0] s2_max_q, s2_min_q, s2_max_d, s2_min_d;
  logic              s3_vld_q, s3_sof_q, s3_eof_q, s3_vld_d, s3_sof_d, s3_eof_d;
  logic [DATA_W-1:0] s3_int_q, s3_int_d;

  // frame statistics
  state_t            state_q, state_d;
  logic [DATA_W-1:0] cur_min_q, cur_max_q, cur_min_d, cur_max_d;
  logic [SUM_W-1:0]  cur_sum_q, cur_sum_d;
  logic [DATA_W-1:0] st_min_q, st_max_q, st_min_d, st_max_d;
  logic [SUM_W-1:0]  st_sum_q, st_sum_d;
  logic              st_vld_q, st_vld_d, ferr_q, ferr_d;

  // combinational helpers
  logic [1:0]        eff_mode;
  logic [COEF_W-1:0] eff_wr, eff_wg, eff_wb;
  logic [DATA_W-1:0] in_max, in_min, s3_res, fold_min, fold_max;
  logic [ACC_W-1:0]  sum_shr;
  logic [SUMX_W-1:0] sum_ext;
  logic [SUM_W-1:0]  fold_sum;

  assign adv     = ~s3_vld_q | iREADY;
  assign sof_acc = iVALID & adv & iSOF;
  assign take    = s3_vld_q & iREADY;

  // An accepted SOF beat already runs with the weights/mode it commits.
  always_comb begin
    eff_mode = sof_acc ? iMODE : act_mode_q;
    eff_wr   = sof_acc ? shd_wr_q : act_wr_q;
    eff_wg   = sof_acc ? shd_wg_q : act_wg_q;
    eff_wb   = sof_acc ? shd_wb_q : act_wb_q;
    if (eff_mode == 2'd3) begin
      eff_wr = W_QTR;
      eff_wg = W_HALF;
      eff_wb = W_QTR;
    end
    in_max = iR;
    if (iG > in_max) in_max = iG;
    if (iB > in_max) in_max = iB;
    in_min = iR;
    if (iG < in_min) in_min = iG;
    if (iB < in_min) in_min = iB;
  end

  // Shadow weights take any load; active set is committed from the old shadow on SOF.
  always_comb begin
    shd_wr_d   = shd_wr_q;
    shd_wg_d   = shd_wg_q;
    shd_wb_d   = shd_wb_q;
    act_wr_d   = act_wr_q;
    act_wg_d   = act_wg_q;
    act_wb_d   = act_wb_q;
    act_mode_d = act_mode_q;
    if (iWLOAD) begin
      shd_wr_d = iWR;
      shd_wg_d = iWG;
      shd_wb_d = iWB;
    end
    if (sof_acc) begin
      act_wr_d   = shd_wr_q;
      act_wg_d   = shd_wg_q;
      act_wb_d   = shd_wb_q;
      act_mode_d = iMODE;
    end
  end

  // Stage-3 result: truncate the weighted sum once, saturate, or pick max/min.
  always_comb begin
    sum_shr = s2_sum_q >> COEF_W;
    case (s2_mode_q)
      2'd1:    s3_res = s2_max_q;
      2'd2:    s3_res = s2_min_q;
      default: s3_res = (|sum_shr[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : sum_shr[DATA_W-1:0];
    endcase
  end

  // Pipeline advance: everything shifts together on adv, otherwise holds.
  always_comb begin
    s1_vld_d = s1_vld_q; s1_sof_d = s1_sof_q; s1_eof_d = s1_eof_q; s1_mode_d = s1_mode_q;
    s1_pr_d  = s1_pr_q;  s1_pg_d  = s1_pg_q;  s1_pb_d  = s1_pb_q;
    s1_max_d = s1_max_q; s1_min_d = s1_min_q;
    s2_vld_d = s2_vld_q; s2_sof_d = s2_sof_q; s2_eof_d = s2_eof_q; s2_mode_d = s2_mode_q;
    s2_sum_d = s2_sum_q; s2_max_d = s2_max_q; s2_min_d = s2_min_q;
    s3_vld_d = s3_vld_q; s3_sof_d = s3_sof_q; s3_eof_d = s3_eof_q; s3_int_d = s3_int_q;
    if (adv) begin
      s1_vld_d  = iVALID;
      s1_sof_d  = iVALID & iSOF;
      s1_eof_d  = iVALID & iEOF;
      s1_mode_d = eff_mode;
      s1_pr_d   = PROD_W'(iR) * PROD_W'(eff_wr);
      s1_pg_d   = PROD_W'(iG) * PROD_W'(eff_wg);
      s1_pb_d   = PROD_W'(iB) * PROD_W'(eff_wb);
      s1_max_d  = in_max;
      s1_min_d  = in_min;
      s2_vld_d  = s1_vld_q;
      s2_sof_d  = s1_sof_q;
      s2_eof_d  = s1_eof_q;
      s2_mode_d = s1_mode_q;
      s2_sum_d  = ACC_W'(s1_pr_q) + ACC_W'(s1_pg_q) + ACC_W'(s1_pb_q);
      s2_max_d  = s1_max_q;
      s2_min_d  = s1_min_q;
      s3_vld_d  = s2_vld_q;
      s3_sof_d  = s2_sof_q;
      s3_eof_d  = s2_eof_q;
      s3_int_d  = s3_res;
    end
  end

  // Frame FSM and statistics, evaluated only on beats taken downstream.
  always_comb begin
    sum_ext  = {1'b0, cur_sum_q} + SUMX_W'(s3_int_q);
    fold_sum = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    fold_min = (s3_int_q < cur_min_q) ? s3_int_q : cur_min_q;
    fold_max = (s3_int_q > cur_max_q) ? s3_int_q : cur_max_q;
    state_d   = state_q;
    cur_min_d = cur_min_q;
    cur_max_d = cur_max_q;
    cur_sum_d = cur_sum_q;
    st_min_d  = st_min_q;
    st_max_d  = st_max_q;
    st_sum_d  = st_sum_q;
    st_vld_d  = 1'b0;
    ferr_d    = 1'b0;
    if (take) begin
      if (s3_sof_q) begin
        ferr_d    = (state_q == ST_ACTIVE);
        cur_min_d = s3_int_q;
        cur_max_d = s3_int_q;
        cur_sum_d = SUM_W'(s3_int_q);
        state_d   = ST_ACTIVE;
        if (s3_eof_q) begin
          st_min_d = s3_int_q;
          st_max_d = s3_int_q;
          st_sum_d = SUM_W'(s3_int_q);
          st_vld_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end else if (state_q == ST_ACTIVE) begin
        cur_min_d = fold_min;
        cur_max_d = fold_max;
        cur_sum_d = fold_sum;
        if (s3_eof_q) begin
          st_min_d = fold_min;
          st_max_d = fold_max;
          st_sum_d = fold_sum;
          st_vld_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      shd_wr_q <= W_QTR; shd_wg_q <= W_HALF; shd_wb_q <= W_QTR;
      act_wr_q <= W_QTR; act_wg_q <= W_HALF; act_wb_q <= W_QTR;
      act_mode_q <= 2'd0;
      s1_vld_q <= 1'b0; s1_sof_q <= 1'b0; s1_eof_q <= 1'b0; s1_mode_q <= 2'd0;
      s1_pr_q <= '0; s1_pg_q <= '0; s1_pb_q <= '0; s1_max_q <= '0; s1_min_q <= '0;
      s2_vld_q <= 1'b0; s2_sof_q <= 1'b0; s2_eof_q <= 1'b0; s2_mode_q <= 2'd0;
      s2_sum_q <= '0; s2_max_q <= '0; s2_min_q <= '0;
      s3_vld_q <= 1'b0; s3_sof_q <= 1'b0; s3_eof_q <= 1'b0; s3_int_q <= '0;
      state_q <= ST_IDLE;
      cur_min_q <= '0; cur_max_q <= '0; cur_sum_q <= '0;
      st_min_q <= '0; st_max_q <= '0; st_sum_q <= '0;
      st_vld_q <= 1'b0; ferr_q <= 1'b0;
    end else begin
      shd_wr_q <= shd_wr_d; shd_wg_q <= shd_wg_d; shd_wb_q <= shd_wb_d;
      act_wr_q <= act_wr_d; act_wg_q <= act_wg_d; act_wb_q <= act_wb_d;
      act_mode_q <= act_mode_d;
      s1_vld_q <= s1_vld_d; s1_sof_q <= s1_sof_d; s1_eof_q <= s1_eof_d; s1_mode_q <= s1_mode_d;
      s1_pr_q <= s1_pr_d; s1_pg_q <= s1_pg_d; s1_pb_q <= s1_pb_d;
      s1_max_q <= s1_max_d; s1_min_q <= s1_min_d;
      s2_vld_q <= s2_vld_d; s2_sof_q <= s2_sof_d; s2_eof_q <= s2_eof_d; s2_mode_q <= s2_mode_d;
      s2_sum_q <= s2_sum_d; s2_max_q <= s2_max_d; s2_min_q <= s2_min_d;
      s3_vld_q <= s3_vld_d; s3_sof_q <= s3_sof_d; s3_eof_q <= s3_eof_d; s3_int_q <= s3_int_d;
      state_q <= state_d;
      cur_min_q <= cur_min_d; cur_max_q <= cur_max_d; cur_sum_q <= cur_sum_d;
      st_min_q <= st_min_d; st_max_q <= st_max_d; st_sum_q <= st_sum_d;
      st_vld_q <= st_vld_d; ferr_q <= ferr_d;
    end
  end

  assign oREADY      = adv;
  assign oVALID      = s3_vld_q;
  assign oSOF        = s3_sof_q;
  assign oEOF        = s3_eof_q;
  assign oIntensity  = s3_int_q;
  assign oSTAT_MIN   = st_min_q;
  assign oSTAT_MAX   = st_max_q;
  assign oSTAT_SUM   = st_sum_q;
  assign oSTAT_VALID = st_vld_q;
  assign oFRAME_ERR  = ferr_q;

endmodule

// File: doc/intensity_calc_pipe.md
Name: intensity_calc_pipe

Overview:
- Parametrised, pipelined successor to the fixed 1/4-1/2-1/4 intensity stage in the Cartoonifier video path, sitting between the VGA pixel source and the edge/posterise stages.
- Adds run-time weights, four reduction modes and valid/ready backpressure with SOF/EOF framing.
- Adds per-frame min/max/sum statistics on the produced intensity, which feed auto-threshold logic downstream.

Parameters:
- DATA_W, 10, width of each colour channel and of the intensity output.
- COEF_W, 8, weight width; weights are unsigned fractions in units of 2^-COEF_W.
- SUM_W, 30, width of the frame-sum accumulator.

Ports:
- iCLK  in  1  pixel clock, 27 MHz VGA clock
- iRST_N  in  1  asynchronous active-low reset
- iR, iG, iB  in  DATA_W each  input pixel
- iVALID  in  1  input beat valid
- iSOF, iEOF  in  1 each  first / last pixel of frame, qualified by iVALID
- oREADY  out  1  upstream may present a beat
- oIntensity  out  DATA_W  intensity result
- oVALID  out  1  output beat valid
- oSOF, oEOF  out  1 each  framing, aligned with oIntensity
- iREADY  in  1  downstream accepts the beat
- iMODE  in  2  0 = programmable weighted, 1 = max(R,G,B), 2 = min(R,G,B), 3 = fixed 1/4,1/2,1/4
- iWLOAD  in  1  one-cycle strobe that captures iWR/iWG/iWB into shadow registers
- iWR, iWG, iWB  in  COEF_W each  new weights
- oSTAT_MIN, oSTAT_MAX  out  DATA_W each  frame min / max intensity
- oSTAT_SUM  out  SUM_W  frame intensity sum, saturating
- oSTAT_VALID  out  1  one-cycle pulse when the statistics update
- oFRAME_ERR  out  1  one-cycle pulse when an SOF arrives inside an open frame

Behaviour:
- Handshake and stall:
  - Global stall with adv = ~oVALID | iREADY. oREADY = adv.
  - An input beat is accepted when iVALID & adv. An output beat is taken when oVALID & iREADY.
  - When adv = 0, every stage register holds.
  - The valid bit travels with the data; bubbles advance only when adv = 1.
- Pipeline:
  - Latency is 3 cycles from acceptance to oVALID when there is no stall.
  - Throughput is 1 beat per cycle.
  - S1: the three products channel*weight, each DATA_W+COEF_W bits, plus max3/min3. Framing bits and mode also register here.
  - S2: sum of the products, DATA_W+COEF_W+2 bits.
  - S3: result selected by the registered mode.
    - Modes 0 and 3: sum >> COEF_W, saturated to 2^DATA_W-1.
    - Mode 1: max3. Mode 2: min3.
- Mode 3 weights are constants 2^(COEF_W-2), 2^(COEF_W-1), 2^(COEF_W-2). Truncation happens once, after the sum.
- Weights and mode:
  - iWLOAD writes the shadow registers on any cycle.
  - Active weights and the active mode are loaded from shadow/iMODE on each accepted beat with iSOF = 1. They stay constant for the rest of the frame.
  - If iWLOAD and an accepted SOF beat occur in the same cycle, the SOF beat commits the old shadow value. The new value waits for the next SOF.
  - The active mode also applies to beats outside any frame.
- Reset values:
  - All valids, oSOF, oEOF, oIntensity and the stat outputs are 0. oSTAT_VALID and oFRAME_ERR are 0.
  - Shadow and active weights are 2^(COEF_W-2), 2^(COEF_W-1), 2^(COEF_W-2). Active mode is 0.
  - Frame FSM is IDLE.
- Frame FSM, evaluated on output beats taken:
  - IDLE + SOF beat: go to ACTIVE; min/max/sum are loaded from this beat.
  - ACTIVE + SOF beat: pulse oFRAME_ERR and restart min/max/sum from this beat.
  - ACTIVE + EOF beat: fold the beat into the stats, update oSTAT_* next cycle with oSTAT_VALID = 1, then go to IDLE.
  - SOF and EOF on the same beat form a single-pixel frame; the stats publish.
  - EOF beat while IDLE: the pixel passes through, no stats update.
  - Beats while IDLE without SOF: they pass through, not counted.
- Sum saturates at 2^SUM_W-1. oSTAT_* hold their values until the next publish.
- Reset mid-frame: the pipeline flushes, the FSM returns to IDLE and no stats publish.

Test Plan:
- Default reset weights, mode 0, R=G=B=1023 -> oIntensity=1023 exactly 3 cycles after acceptance. R=400, G=200, B=0 -> 200.
- Load weights 255/255/255, then SOF beat with R=G=B=1023 -> saturates to 1023. Load issued mid-frame -> no effect until the next SOF.
- Mode 1 with R=100, G=700, B=300 -> 700. Mode 2 on the same pixel -> 100. Mode 3 with 1023/0/1023 -> 511.
- Stream 8 beats while holding iREADY=0 for cycles 2-5 -> oREADY=0 during the hold, no beat lost or duplicated, output order preserved.
- Frame of 4 beats with intensities 10, 500, 3, 77 (SOF on first, EOF on last) -> MIN=3, MAX=500, SUM=590, oSTAT_VALID one pulse.
- SOF, 2 beats, SOF again -> oFRAME_ERR pulse and stats restart. Assert iRST_N low mid-frame -> outputs and valids 0, no oSTAT_VALID.
